frog_collision_detect: RTL and testbench
========================================

// Module: frog_collision_detect
// PURPOSE
//  Consumes the flattened car X/Y bus from the car controller and the frog grid position.
//  Scans one car per clock and flags a collision when a car shares the frog's tile.
//  Maintains the lives counter and game-over state, with a post-hit invulnerability holdoff.
//  Sits between car/frog control and the VGA/score logic.
// PARAMETERS
//  NUM_CARS      10       number of cars on i_Car_X/i_Car_Y (6-bit fields each)
//  c_LIVES       3        lives loaded at reset and on restart (1..7)
//  c_HOLDOFF     2500000  clocks of invulnerability after a hit (~0.1 s at 25 MHz)
//  HOLDOFF_W     22       holdoff counter width; must satisfy 2**HOLDOFF_W > c_HOLDOFF
// PORTS
//  i_Clk        in   1           system clock
//  i_Rst_L      in   1           asynchronous active-low reset
//  i_Car_X      in   NUM_CARS*6  car i X at [i*6+:6]
//  i_Car_Y      in   NUM_CARS*6  car i Y at [i*6+:6]
//  i_Frog_X     in   6           frog tile X
//  i_Frog_Y     in   6           frog tile Y
//  i_Restart    in   1           1-clk pulse; reloads lives, leaves GAME_OVER
//  o_Hit        out  1           1-clk pulse per accepted collision
//  o_Lives      out  3           remaining lives
//  o_Game_Over  out  1           high while in GAME_OVER
//  o_Invuln     out  1           high while the holdoff counter is nonzero
// BEHAVIOUR
//  Reset (async, i_Rst_L=0): state=SCAN, idx=0, o_Hit=0, o_Lives=c_LIVES, o_Game_Over=0,
//   holdoff=0, o_Invuln=0, and the hit accumulator and frog snapshot are cleared.
//  SCAN, idx==0: snapshot i_Frog_X/Y and the full car buses; clear the accumulator.
//  Every SCAN clock: acc |= (carY[idx]==frogY) && (carX[idx]==frogX), using snapshot values.
//   Inputs that change mid-pass are ignored until the next pass.
//  idx==NUM_CARS-1: idx wraps to 0 and the pass is evaluated on the next clock (EVAL).
//  EVAL (1 clk): if acc && holdoff==0: o_Hit=1 for that clk, lives -= 1, holdoff=c_HOLDOFF.
//   If lives becomes 0: state=GAME_OVER. Otherwise state returns to SCAN.
//  Latency: frog/car overlap present at a snapshot produces o_Hit NUM_CARS+1 clocks later.
//  Holdoff: decrements by 1 each clock while nonzero, in every state. Hits while nonzero are dropped.
//  GAME_OVER: o_Game_Over=1, no scanning, o_Hit=0, lives held at 0 (never wraps below 0).
//  i_Restart (any state): next clock state=SCAN, idx=0, lives=c_LIVES, holdoff=0, acc=0.
//   Restart wins over a simultaneous EVAL hit: no o_Hit and no decrement.
//  Comparisons are 6-bit unsigned equality; there is no clamping of out-of-range coordinates.
// CONFIGURATION
//  CAR_WIDE_EN defined: each car covers tiles X and X+1. A match is
//   frogX==carX || frogX==(carX+1) mod 64, same Y.
//  CAR_WIDE_EN undefined: a car covers only tile X (exact match).
// STRUCTURE
//  frog_game_pkg.vh: COORD_W=6, state encodings ST_SCAN/ST_EVAL/ST_GAME_OVER, LIVES_W=3.
//   Shared with frog and score blocks.
//  One sub-module, collision_holdoff_timer: load/decrement/nonzero flag, c_HOLDOFF and HOLDOFF_W passed in.
//  Scan index counter, FSM, snapshot registers and lives counter live in the top module.
// TESTING  (benches override c_HOLDOFF=20, NUM_CARS=10)
//  Frog (3,3), car3=(3,3) -> o_Hit 1 clk, 11 clks after snapshot; o_Lives 3->2; o_Invuln high 20 clks.
//  Overlap held through the holdoff -> no second hit until holdoff=0, then a hit on the next EVAL; lives 2->1.
//  Three accepted hits from lives=3 -> o_Lives=0, o_Game_Over=1, no o_Hit on further overlaps.
//  i_Restart in GAME_OVER -> o_Lives=3, o_Game_Over=0 the next clk; scanning resumes at idx 0.
//  CAR_WIDE_EN with car0=(63,1), frog (0,1) -> hit (wrap). Without the macro -> no hit.
//  i_Rst_L low mid-pass (idx=5) with acc set -> o_Hit never pulses; all outputs at reset values immediately.

Source files
------------

// File: rtl/frog_game_pkg.sv
// rtl/frog_game_pkg.sv - shared frog game constants, FSM states and car/frog tile match (CAR_WIDE_EN)
package frog_game_pkg;

    localparam int COORD_W = 6;
    localparam int LIVES_W = 3;

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_EVAL      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    function automatic logic car_hits_frog(
        input logic [COORD_W-1:0] car_x,
        input logic [COORD_W-1:0] car_y,
        input logic [COORD_W-1:0] frog_x,
        input logic [COORD_W-1:0] frog_y
    );
`ifdef CAR_WIDE_EN
        // A wide car also covers the tile to its right, wrapping at the grid edge
        return (car_y == frog_y) && ((car_x == frog_x) || (car_x + 6'd1 == frog_x));
`else
        return (car_y == frog_y) && (car_x == frog_x);
`endif
    endfunction

endpackage

// File: rtl/collision_holdoff_timer.sv
// rtl/collision_holdoff_timer.sv - post-hit invulnerability down-counter with load, clear and nonzero flag
module collision_holdoff_timer #(
    parameter int c_HOLDOFF = 2500000,
    parameter int HOLDOFF_W = 22
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Load,
    input  logic i_Clear,
    output logic o_Nonzero
);

    logic [HOLDOFF_W-1:0] r_count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_count <= '0;
        end else if (i_Clear) begin
            r_count <= '0;
        end else if (i_Load) begin
            r_count <= HOLDOFF_W'(c_HOLDOFF);
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_Nonzero = (r_count != '0);

endmodule

// File: rtl/frog_collision_detect.sv
// rtl/frog_collision_detect.sv - scans one car per clock for frog overlap, tracks lives and game over
// Optional CAR_WIDE_EN: cars cover two adjacent tiles (see frog_game_pkg::car_hits_frog).
module frog_collision_detect
    import frog_game_pkg::*;
#(
    parameter int NUM_CARS  = 10,
    parameter int c_LIVES   = 3,
    parameter int c_HOLDOFF = 2500000,
    parameter int HOLDOFF_W = 22
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_L,
    input  logic [NUM_CARS*COORD_W-1:0]  i_Car_X,
    input  logic [NUM_CARS*COORD_W-1:0]  i_Car_Y,
    input  logic [COORD_W-1:0]           i_Frog_X,
    input  logic [COORD_W-1:0]           i_Frog_Y,
    input  logic                         i_Restart,
    output logic                         o_Hit,
    output logic [LIVES_W-1:0]           o_Lives,
    output logic                         o_Game_Over,
    output logic                         o_Invuln
);

    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    state_t                        r_state;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_acc;
    logic                          r_hit;
    logic                          r_game_over;
    logic [LIVES_W-1:0]            r_lives;
    logic [COORD_W-1:0]            r_frog_x;
    logic [COORD_W-1:0]            r_frog_y;
    logic [NUM_CARS*COORD_W-1:0]   r_car_x;
    logic [NUM_CARS*COORD_W-1:0]   r_car_y;

    logic [COORD_W-1:0]            w_snap_cx;
    logic [COORD_W-1:0]            w_snap_cy;
    logic                          w_match;
    logic                          w_invuln;
    logic                          w_accept;

    assign w_snap_cx = r_car_x[r_idx*COORD_W +: COORD_W];
    assign w_snap_cy = r_car_y[r_idx*COORD_W +: COORD_W];

    // Car 0 is compared in the same clock the snapshot is captured, so it uses the live inputs
    assign w_match = (r_idx == '0)
                   ? car_hits_frog(i_Car_X[0 +: COORD_W], i_Car_Y[0 +: COORD_W], i_Frog_X, i_Frog_Y)
                   : car_hits_frog(w_snap_cx, w_snap_cy, r_frog_x, r_frog_y);

    assign w_accept = (r_state == ST_EVAL) && r_acc && !w_invuln && !i_Restart;

    collision_holdoff_timer #(
        .c_HOLDOFF (c_HOLDOFF),
        .HOLDOFF_W (HOLDOFF_W)
    ) u_holdoff (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Load    (w_accept),
        .i_Clear   (i_Restart),
        .o_Nonzero (w_invuln)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= ST_SCAN;
            r_idx       <= '0;
            r_acc       <= 1'b0;
            r_hit       <= 1'b0;
            r_game_over <= 1'b0;
            r_lives     <= LIVES_W'(c_LIVES);
            r_frog_x    <= '0;
            r_frog_y    <= '0;
            r_car_x     <= '0;
            r_car_y     <= '0;
        end else if (i_Restart) begin
            r_state     <= ST_SCAN;
            r_idx       <= '0;
            r_acc       <= 1'b0;
            r_hit       <= 1'b0;
            r_game_over <= 1'b0;
            r_lives     <= LIVES_W'(c_LIVES);
        end else begin
            case (r_state)
                ST_SCAN: begin
                    r_hit <= 1'b0;
                    if (r_idx == '0) begin
                        r_frog_x <= i_Frog_X;
                        r_frog_y <= i_Frog_Y;
                        r_car_x  <= i_Car_X;
                        r_car_y  <= i_Car_Y;
                        r_acc    <= w_match;
                    end else begin
                        r_acc    <= r_acc | w_match;
                    end
                    if (r_idx == IDX_W'(NUM_CARS - 1)) begin
                        r_idx   <= '0;
                        r_state <= ST_EVAL;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                ST_EVAL: begin
                    r_hit <= w_accept;
                    if (w_accept && r_lives == LIVES_W'(1)) begin
                        r_lives     <= '0;
                        r_game_over <= 1'b1;
                        r_state     <= ST_GAME_OVER;
                    end else begin
                        if (w_accept) begin
                            r_lives <= r_lives - 1'b1;
                        end
                        r_state <= ST_SCAN;
                    end
                end
                default: begin
                    r_hit       <= 1'b0;
                    r_game_over <= 1'b1;
                end
            endcase
        end
    end

    assign o_Hit       = r_hit;
    assign o_Lives     = r_lives;
    assign o_Game_Over = r_game_over;
    assign o_Invuln    = w_invuln;

endmodule

// File: tb/tb_frog_collision_detect.sv
// tb/tb_frog_collision_detect.sv - bench for frog_collision_detect: pass-level model plus directed pins (CAR_WIDE_EN aware)
module tb_frog_collision_detect;

    localparam int NC   = 10;
    localparam int LIV  = 3;
    localparam int HOLD = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [59:0]  car_x;
    logic [59:0]  car_y;
    logic [5:0]   frog_x;
    logic [5:0]   frog_y;
    logic         restart;
    logic         o_hit;
    logic [2:0]   o_lives;
    logic         o_go;
    logic         o_inv;

    int checks = 0;
    int errors = 0;

    // Reference model state: pass position, snapshot, lives, holdoff
    int m_phase, m_lives, m_hold;
    bit m_hit, m_go;
    int snap_fx, snap_fy;
    int snap_cx[NC];
    int snap_cy[NC];

    always #5 clk = ~clk;

    frog_collision_detect #(
        .NUM_CARS  (NC),
        .c_LIVES   (LIV),
        .c_HOLDOFF (HOLD),
        .HOLDOFF_W (5)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Car_X     (car_x),
        .i_Car_Y     (car_y),
        .i_Frog_X    (frog_x),
        .i_Frog_Y    (frog_y),
        .i_Restart   (restart),
        .o_Hit       (o_hit),
        .o_Lives     (o_lives),
        .o_Game_Over (o_go),
        .o_Invuln    (o_inv)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit m_match(input int cx, input int cy, input int fx, input int fy);
`ifdef CAR_WIDE_EN
        return (cy == fy) && ((cx == fx) || (((cx + 1) % 64) == fx));
`else
        return (cy == fy) && (cx == fx);
`endif
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lives = LIV; m_hold = 0; m_hit = 0; m_go = 0;
    endtask

    task automatic model_step();
        int  nh;
        bit  any;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (restart) begin
            m_phase = 0; m_lives = LIV; m_hold = 0; m_go = 0; m_hit = 0;
            return;
        end
        m_hit = 0;
        nh = (m_hold > 0) ? m_hold - 1 : 0;
        if (!m_go) begin
            if (m_phase < NC) begin
                if (m_phase == 0) begin
                    snap_fx = int'(frog_x);
                    snap_fy = int'(frog_y);
                    for (int i = 0; i < NC; i++) begin
                        snap_cx[i] = int'(car_x[i*6 +: 6]);
                        snap_cy[i] = int'(car_y[i*6 +: 6]);
                    end
                end
                m_phase++;
            end else begin
                any = 0;
                for (int i = 0; i < NC; i++)
                    if (m_match(snap_cx[i], snap_cy[i], snap_fx, snap_fy)) any = 1;
                if (any && m_hold == 0) begin
                    m_hit = 1;
                    m_lives--;
                    nh = HOLD;
                    if (m_lives == 0) m_go = 1;
                end
                m_phase = 0;
            end
        end
        m_hold = nh;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_car(input int i, input int x, input int y);
        car_x[i*6 +: 6] = 6'(x);
        car_y[i*6 +: 6] = 6'(y);
    endtask

    task automatic park_cars();
        for (int i = 0; i < NC; i++) set_car(i, 10 + i, 40);
    endtask

    // Continuous comparison against the model on the falling edge
    always @(negedge clk) begin
        chk("hit", int'(o_hit), int'(m_hit));
        chk("lives", int'(o_lives), m_lives);
        chk("game_over", int'(o_go), int'(m_go));
        chk("invuln", int'(o_inv), int'(m_hold != 0));
    end

    initial begin
        int hit_at[$];
        int inv_cnt, hits, h0, h1, h2, exp_wide;

        model_reset();
        rst_n = 1'b0; restart = 1'b0;
        park_cars();
        set_car(3, 3, 3);
        frog_x = 6'd3; frog_y = 6'd3;
        cyc(); cyc();
        chk("reset_lives", int'(o_lives), 3);
        chk("reset_hit", int'(o_hit), 0);
        chk("reset_go", int'(o_go), 0);
        chk("reset_invuln", int'(o_inv), 0);
        rst_n = 1'b1;

        // Held overlap: hits at 11, 33, 55 then game over
        inv_cnt = 0;
        for (int n = 1; n <= 80; n++) begin
            cyc();
            if (o_hit) hit_at.push_back(n);
            if (o_inv && n >= 11 && n <= 32) inv_cnt++;
            if (n == 12) chk("lives_after_first_hit", int'(o_lives), 2);
            if (n == 34) chk("lives_after_second_hit", int'(o_lives), 1);
        end
        h0 = (hit_at.size() > 0) ? hit_at[0] : -1;
        h1 = (hit_at.size() > 1) ? hit_at[1] : -1;
        h2 = (hit_at.size() > 2) ? hit_at[2] : -1;
        chk("hit_count_held_overlap", hit_at.size(), 3);
        chk("first_hit_cycle", h0, 11);
        chk("second_hit_cycle", h1, 33);
        chk("third_hit_cycle", h2, 55);
        chk("invuln_cycles", inv_cnt, 20);
        chk("lives_at_game_over", int'(o_lives), 0);
        chk("game_over_flag", int'(o_go), 1);

        restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("restart_lives", int'(o_lives), 3);
        chk("restart_go", int'(o_go), 0);

        // Async reset mid-pass with the accumulator already set
        repeat (6) cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_hit", int'(o_hit), 0);
        chk("async_rst_lives", int'(o_lives), 3);
        chk("async_rst_go", int'(o_go), 0);
        chk("async_rst_invuln", int'(o_inv), 0);
        hits = 0;
        repeat (3) begin cyc(); hits += int'(o_hit); end
        rst_n = 1'b1;
        repeat (5) begin cyc(); hits += int'(o_hit); end
        chk("no_hit_after_reset", hits, 0);

        // Wraparound tile: only a wide car reaches frog at X=0 from X=63
        park_cars();
        set_car(0, 63, 1);
        frog_x = 6'd0; frog_y = 6'd1;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        hits = 0;
        repeat (12) begin cyc(); hits += int'(o_hit); end
`ifdef CAR_WIDE_EN
        exp_wide = 1;
`else
        exp_wide = 0;
`endif
        chk("wrap_hit_count", hits, exp_wide);

        // Randomized traffic, restarts and async resets
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 3) == 0)
                    set_car(i, ($urandom_range(0, 15) == 0) ? 63 : $urandom_range(0, 7), $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) begin
                frog_x = 6'($urandom_range(0, 7));
                frog_y = 6'($urandom_range(0, 7));
            end
            restart = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end
        restart = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
